// File: rtl/vga_draw_pkg.sv
// Shared types for the rectangle-fill bus master: FSM states, register
// offsets inside the VGA peripheral window, default geometry, command struct
// and the coordinate clipping helpers.
package vga_draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WR_X,
        ST_WR_Y,
        ST_WR_P,
        ST_FIN
    } state_t;

    localparam logic [7:0] X_OFS   = 8'd0;
    localparam logic [7:0] Y_OFS   = 8'd1;
    localparam logic [7:0] PIX_OFS = 8'd2;

    localparam int         DEF_X_MAX     = 159;
    localparam int         DEF_Y_MAX     = 119;
    localparam logic [7:0] DEF_IDLE_ADDR = 8'hFF;

    typedef struct packed {
        logic [7:0] x0;
        logic [6:0] y0;
        logic [7:0] x1;
        logic [6:0] y1;
        logic       pixel;
    } rect_cmd_t;

    // Coordinates beyond the frame saturate to the last valid column/row.
    function automatic logic [7:0] clip_x(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [6:0] clip_y(input logic [6:0] v, input logic [6:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/vga_draw_if.sv
// Command handshake and bus-side control signals of the rectangle-fill
// master. The tri-state data bus stays a plain inout on the top module.
interface vga_draw_if;
    import vga_draw_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    rect_cmd_t  cmd;
    logic       bus_req;
    logic       bus_gnt;
    logic       bus_own;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       busy;
    logic       done;

    modport master (
        input  cmd_valid, cmd, bus_gnt,
        output cmd_ready, bus_req, bus_own, bus_addr, bus_we, busy, done
    );

    modport slave (
        output cmd_valid, cmd, bus_gnt,
        input  cmd_ready, bus_req, bus_own, bus_addr, bus_we, busy, done
    );

endinterface

// File: rtl/vga_draw_rect_walker.sv
// Holds the clipped rectangle bounds and the current point, and walks the
// rectangle in raster order one step at a time. Flags an empty rectangle
// combinationally from the incoming command so the FSM can skip the bus.
module vga_draw_rect_walker
    import vga_draw_pkg::*;
#(
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_MAX = DEF_Y_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  rect_cmd_t  cmd,
    input  logic       step,
    output logic       empty,
    output logic [7:0] cur_x,
    output logic [7:0] next_x,
    output logic [6:0] cur_y,
    output logic       pixel,
    output logic       last,
    output logic       row_change
);
    localparam logic [7:0] XM = 8'(X_MAX);
    localparam logic [6:0] YM = 7'(Y_MAX);

    logic [7:0] cx0, cx1;
    logic [6:0] cy0, cy1;
    logic [7:0] x0, x1;
    logic [6:0] y1;

    assign cx0   = clip_x(cmd.x0, XM);
    assign cx1   = clip_x(cmd.x1, XM);
    assign cy0   = clip_y(cmd.y0, YM);
    assign cy1   = clip_y(cmd.y1, YM);
    assign empty = (cx0 > cx1) || (cy0 > cy1);

    // row_change: the next step wraps to the left column of the next row
    assign row_change = (cur_x == x1);
    assign last       = row_change && (cur_y == y1);
    assign next_x     = row_change ? x0 : cur_x + 8'd1;

    // Latch clipped bounds on load, advance the point on step.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0    <= '0;
            x1    <= '0;
            y1    <= '0;
            cur_x <= '0;
            cur_y <= '0;
            pixel <= 1'b0;
        end else if (load) begin
            x0    <= cx0;
            x1    <= cx1;
            y1    <= cy1;
            cur_x <= cx0;
            cur_y <= cy0;
            pixel <= cmd.pixel;
        end else if (step && !last) begin
            cur_x <= next_x;
            if (row_change)
                cur_y <= cur_y + 7'd1;
        end
    end

endmodule

// File: rtl/vga_draw_master.sv
// Rectangle-fill bus initiator: accepts one rectangle command, requests the
// bus and writes X, Y, pixel to the VGA peripheral for every point.
// Optional feature macro: VGA_DRAW_YSKIP_EN (omit the Y write while the row
// already written in the current grant is unchanged).
module vga_draw_master
    import vga_draw_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter int         X_MAX     = DEF_X_MAX,
    parameter int         Y_MAX     = DEF_Y_MAX,
    parameter logic [7:0] IDLE_ADDR = DEF_IDLE_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    vga_draw_if.master bus,
    inout  wire  [7:0] bus_data
);
`ifdef VGA_DRAW_YSKIP_EN
    localparam bit YSKIP = 1'b1;
`else
    localparam bit YSKIP = 1'b0;
`endif

    state_t     state;
    logic       ready_q, req_q, own_q, we_q, busy_q, done_q;
    logic [7:0] addr_q, data_q;
    logic       y_valid;   // Y register holds cur_y, written during this grant

    logic       empty, pixel, last, row_change;
    logic [7:0] cur_x, next_x;
    logic [6:0] cur_y;

    vga_draw_rect_walker #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_walker (
        .clk        (clk),
        .reset      (reset),
        .load       (ready_q & bus.cmd_valid),
        .cmd        (bus.cmd),
        .step       (state == ST_WR_P),
        .empty      (empty),
        .cur_x      (cur_x),
        .next_x     (next_x),
        .cur_y      (cur_y),
        .pixel      (pixel),
        .last       (last),
        .row_change (row_change)
    );

    assign bus.cmd_ready = ready_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_own   = own_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus_data      = (own_q & we_q) ? data_q : 8'bz;

    // Command/bus sequencer. Outputs are registered on entry to a state, so a
    // write is launched only at an edge where grant is seen; a grant sampled
    // low cancels the next write and the point restarts from X after regrant.
    // A write already on the bus when grant falls has completed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            own_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= IDLE_ADDR;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            own_q  <= 1'b0;
            addr_q <= IDLE_ADDR;
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        y_valid <= 1'b0;
                        if (empty) begin
                            state  <= ST_FIN;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                            req_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.bus_gnt) begin
                        state  <= ST_WR_X;
                        we_q   <= 1'b1;
                        own_q  <= 1'b1;
                        addr_q <= BASE_ADDR + X_OFS;
                        data_q <= cur_x;
                    end
                end
                ST_WR_X: begin
                    if (!bus.bus_gnt) begin
                        state   <= ST_REQ;
                        y_valid <= 1'b0;
                    end else if (YSKIP && y_valid) begin
                        state  <= ST_WR_P;
                        we_q   <= 1'b1;
                        own_q  <= 1'b1;
                        addr_q <= BASE_ADDR + PIX_OFS;
                        data_q <= {7'b0, pixel};
                    end else begin
                        state   <= ST_WR_Y;
                        we_q    <= 1'b1;
                        own_q   <= 1'b1;
                        addr_q  <= BASE_ADDR + Y_OFS;
                        data_q  <= {1'b0, cur_y};
                        y_valid <= 1'b1;
                    end
                end
                ST_WR_Y: begin
                    if (!bus.bus_gnt) begin
                        state   <= ST_REQ;
                        y_valid <= 1'b0;
                    end else begin
                        state  <= ST_WR_P;
                        we_q   <= 1'b1;
                        own_q  <= 1'b1;
                        addr_q <= BASE_ADDR + PIX_OFS;
                        data_q <= {7'b0, pixel};
                    end
                end
                ST_WR_P: begin
                    if (last) begin
                        state  <= ST_FIN;
                        req_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else if (!bus.bus_gnt) begin
                        state   <= ST_REQ;
                        y_valid <= 1'b0;
                    end else begin
                        state  <= ST_WR_X;
                        we_q   <= 1'b1;
                        own_q  <= 1'b1;
                        addr_q <= BASE_ADDR + X_OFS;
                        data_q <= next_x;
                        if (row_change)
                            y_valid <= 1'b0;
                    end
                end
                ST_FIN: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_draw_master.sv
// Self-checking bench for vga_draw_master: directed cases plus randomized
// rectangles checked against a raster-order write-list model.
module tb_vga_draw_master;
    import vga_draw_pkg::*;

    localparam logic [7:0] BASE = 8'hB0;
`ifdef VGA_DRAW_YSKIP_EN
    localparam bit YSKIP = 1'b1;
`else
    localparam bit YSKIP = 1'b0;
`endif

    logic      clk   = 1'b0;
    logic      reset = 1'b1;
    wire [7:0] bus_data;

    vga_draw_if intf();

    vga_draw_master dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (intf),
        .bus_data (bus_data)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    int          cyc      = 0;
    int          first_we = -1;
    int          done_cnt = 0;
    int          req_cnt  = 0;
    logic        gnt_at_edge = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // edge counter and the grant value the DUT saw at each edge
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        gnt_at_edge <= intf.bus_gnt;
    end

    // bus monitor: collect writes, check idle address and write legality
    always @(negedge clk) begin
        if (!reset) begin
            if (intf.bus_we) begin
                got.push_back({intf.bus_addr, bus_data});
                if (first_we < 0) first_we = cyc;
                chk("own_on_write", intf.bus_own, 1);
                chk("grant_before_write", gnt_at_edge, 1);
            end else begin
                chk("idle_addr", intf.bus_addr, 8'hFF);
            end
            if (intf.done) done_cnt++;
            if (intf.bus_req) req_cnt++;
        end
    end

    // reference model: expected write list for a rectangle with grant held
    task automatic build_exp(input int x0, input int y0, input int x1, input int y1, input bit pix);
        int cx0, cx1, cy0, cy1;
        cx0 = (x0 > 159) ? 159 : x0;
        cx1 = (x1 > 159) ? 159 : x1;
        cy0 = (y0 > 119) ? 119 : y0;
        cy1 = (y1 > 119) ? 119 : y1;
        exp_q.delete();
        for (int y = cy0; y <= cy1; y++) begin
            for (int x = cx0; x <= cx1; x++) begin
                exp_q.push_back({BASE, 8'(x)});
                if (!YSKIP || x == cx0) exp_q.push_back({BASE + 8'd1, 8'(y)});
                exp_q.push_back({BASE + 8'd2, 7'b0, pix});
            end
        end
    endtask

    task automatic compare_writes(input string tag);
        int n;
        chk({tag, "_nwrites"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic offer(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] x1,
                         input logic [6:0] y1, input logic pix);
        got.delete();
        first_we = -1;
        done_cnt = 0;
        req_cnt  = 0;
        intf.cmd.x0    = x0;
        intf.cmd.y0    = y0;
        intf.cmd.x1    = x1;
        intf.cmd.y1    = y1;
        intf.cmd.pixel = pix;
        intf.cmd_valid = 1'b1;
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] x0, input logic [6:0] y0,
                           input logic [7:0] x1, input logic [6:0] y1, input logic pix);
        int acc, n;
        build_exp(x0, y0, x1, y1, pix);
        chk({tag, "_ready"}, intf.cmd_ready, 1);
        offer(x0, y0, x1, y1, pix);
        acc = cyc;
        @(negedge clk);
        intf.cmd_valid = 1'b0;
        chk({tag, "_busy"}, intf.busy, 1);
        n = 0;
        while (!intf.done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, intf.done, 1);
        if (exp_q.size() == 0) chk({tag, "_done_lat"}, n, 0);
        else chk({tag, "_first_we_lat"}, first_we - acc, 2);
        @(negedge clk);
        @(negedge clk);
        compare_writes(tag);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_ready_after"}, intf.cmd_ready, 1);
        chk({tag, "_busy_after"}, intf.busy, 0);
        if (exp_q.size() == 0) chk({tag, "_no_req"}, req_cnt, 0);
    endtask

    initial begin
        int n, pcnt, snap, lastx;
        logic [7:0] rx0, rx1;
        logic [6:0] ry0, ry1;
        intf.cmd_valid = 1'b0;
        intf.cmd       = '0;
        intf.bus_gnt   = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", intf.cmd_ready, 1);
        chk("rst_req",   intf.bus_req, 0);
        chk("rst_own",   intf.bus_own, 0);
        chk("rst_we",    intf.bus_we, 0);
        chk("rst_addr",  intf.bus_addr, 8'hFF);
        chk("rst_busy",  intf.busy, 0);
        chk("rst_done",  intf.done, 0);
        reset = 1'b0;
        @(negedge clk);

        // 2x2 rectangle, grant held
        run_cmd("t1", 8'd10, 7'd20, 8'd11, 7'd21, 1'b1);

        // right edge clipped to the last column
        run_cmd("t2", 8'd150, 7'd119, 8'd200, 7'd119, 1'b0);
        lastx = -1;
        foreach (got[i]) if (got[i][15:8] == BASE) lastx = int'(got[i][7:0]);
        chk("t2_last_x", lastx, 159);

        // empty rectangle: no bus activity
        run_cmd("t3", 8'd5, 7'd3, 8'd4, 7'd3, 1'b1);

        // grant lost just before the Y write of the second point
        exp_q.delete();
        exp_q = '{16'hB00A, 16'hB114, 16'hB201, 16'hB00B,
                  16'hB00B, 16'hB114, 16'hB201,
                  16'hB00A, 16'hB115, 16'hB201, 16'hB00B};
        if (!YSKIP) exp_q.push_back(16'hB115);
        exp_q.push_back(16'hB201);
        offer(8'd10, 7'd20, 8'd11, 7'd21, 1'b1);
        @(negedge clk);
        intf.cmd_valid = 1'b0;
        n = 0;
        while (!(intf.bus_we && intf.bus_addr == BASE && bus_data == 8'd11) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_x2_seen", intf.bus_we, 1);
        intf.bus_gnt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t4_no_we_in_drop", intf.bus_we, 0);
            chk("t4_req_held", intf.bus_req, 1);
        end
        intf.bus_gnt = 1'b1;
        n = 0;
        while (!intf.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_done_seen", intf.done, 1);
        @(negedge clk);
        @(negedge clk);
        compare_writes("t4");
        pcnt = 0;
        foreach (got[i]) if (got[i][15:8] == BASE + 8'd2) pcnt++;
        chk("t4_pix_writes", pcnt, 4);
        chk("t4_done_cnt", done_cnt, 1);

        // reset during the third pixel write
        offer(8'd10, 7'd20, 8'd11, 7'd21, 1'b1);
        @(negedge clk);
        intf.cmd_valid = 1'b0;
        pcnt = 0;
        n = 0;
        while (pcnt < 3 && n < 200) begin
            if (intf.bus_we && intf.bus_addr == BASE + 8'd2) pcnt++;
            if (pcnt < 3) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t5_third_pix_seen", pcnt, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_we",    intf.bus_we, 0);
        chk("t5_req",   intf.bus_req, 0);
        chk("t5_own",   intf.bus_own, 0);
        chk("t5_addr",  intf.bus_addr, 8'hFF);
        chk("t5_ready", intf.cmd_ready, 1);
        chk("t5_done",  intf.done, 0);
        chk("t5_busy",  intf.busy, 0);
        reset = 1'b0;
        snap = got.size();
        repeat (6) @(negedge clk);
        chk("t5_no_more_writes", got.size(), snap);
        chk("t5_no_done", done_cnt, 0);

        // randomized rectangles, some clipped, some empty
        for (int k = 0; k < 16; k++) begin
            rx0 = 8'($urandom_range(0, 175));
            rx1 = 8'(int'(rx0) + $urandom_range(0, 7) - 1);
            if (rx0 == 8'd0 && rx1 == 8'hFF) rx1 = 8'd0;
            ry0 = 7'($urandom_range(0, 125));
            ry1 = 7'(int'(ry0) + $urandom_range(0, 3) - 1);
            if (ry0 == 7'd0 && ry1 == 7'h7F) ry1 = 7'd0;
            run_cmd($sformatf("rnd%0d", k), rx0, ry0, rx1, ry1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
